// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word sequencer onto a byte-wide 256x8 RAM.
// Define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word requests.
module mem_access_ctrl #(
  parameter int RAM_LAT    = 0,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  dt,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        moc,
  output logic        busy,
  output logic        err,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        ram_en,
  output logic        ram_we
);

  localparam int CW = (RAM_LAT > 0) ? $clog2(RAM_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE,
    ERR
  } state_t;

  state_t      state, state_n;
  logic        rw_q, rw_n;
  logic [1:0]  last_q, last_n;
  logic [1:0]  k_q, k_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [31:0] wdata_q, wdata_n;
  logic [31:0] acc_q, acc_n;
  logic [31:0] rdata_n;
  logic        moc_n, busy_n, err_n;
  logic        ram_en_n, ram_we_n;
  logic [7:0]  ram_addr_n, ram_wdata_n;
  logic        misal;
  logic [1:0]  req_last;

  // index of the final byte: 0, 1 or 3
  function automatic logic [1:0] last_of(input logic [1:0] d);
    unique case (d)
      2'b01:   return 2'd1;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // which byte lane of the data word holds byte k
  function automatic logic [1:0] lane(input logic [1:0] last,
                                      input logic [1:0] k);
    if (BIG_ENDIAN)
      return last - k;
    else
      return k;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] d,
                                          input logic [1:0] ln);
    return d[{ln, 3'b000} +: 8];
  endfunction

  assign req_last = last_of(dt);

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = (dt == 2'b01 && addr[0]) ||
                 (dt == 2'b10 && addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  // next-state and next-output logic; outputs are all registered
  always_comb begin
    state_n     = state;
    rw_n        = rw_q;
    last_n      = last_q;
    k_n         = k_q;
    cnt_n       = cnt_q;
    wdata_n     = wdata_q;
    acc_n       = acc_q;
    rdata_n     = rdata;
    moc_n       = 1'b0;
    err_n       = 1'b0;
    busy_n      = busy;
    ram_en_n    = ram_en;
    ram_we_n    = ram_we;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (req) begin
          if (dt == 2'b11 || misal) begin
            state_n = ERR;
            err_n   = 1'b1;
          end else begin
            state_n     = XFER;
            rw_n        = rw;
            last_n      = req_last;
            wdata_n     = wdata;
            k_n         = 2'd0;
            cnt_n       = '0;
            acc_n       = '0;
            busy_n      = 1'b1;
            ram_en_n    = 1'b1;
            ram_we_n    = !rw;
            ram_addr_n  = addr;
            ram_wdata_n = get_byte(wdata, lane(req_last, 2'd0));
          end
        end
      end
      XFER: begin
        if (cnt_q == CW'(RAM_LAT)) begin
          if (rw_q)
            acc_n[{lane(last_q, k_q), 3'b000} +: 8] = ram_rdata;
          if (k_q == last_q) begin
            state_n  = DONE;
            moc_n    = 1'b1;
            ram_en_n = 1'b0;
            ram_we_n = 1'b0;
            if (rw_q)
              rdata_n = acc_n;
          end else begin
            k_n         = k_q + 2'd1;
            cnt_n       = '0;
            ram_addr_n  = ram_addr + 8'd1;
            ram_wdata_n = get_byte(wdata_q,
                                   lane(last_q, k_q + 2'd1));
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      ERR: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // state, context and output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      last_q    <= 2'd0;
      k_q       <= 2'd0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
      rdata     <= '0;
      moc       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_n;
      rw_q      <= rw_n;
      last_q    <= last_n;
      k_q       <= k_n;
      cnt_q     <= cnt_n;
      wdata_q   <= wdata_n;
      acc_q     <= acc_n;
      rdata     <= rdata_n;
      moc       <= moc_n;
      busy      <= busy_n;
      err       <= err_n;
      ram_en    <= ram_en_n;
      ram_we    <= ram_we_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks on three mem_access_ctrl builds.
// u0: L=0 big-endian, u1: L=1 big-endian, u2: L=2 little-endian.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req   [3];
  logic        rw    [3];
  logic [1:0]  dt    [3];
  logic [7:0]  addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        moc   [3];
  logic        busy  [3];
  logic        err   [3];
  logic [7:0]  ram_addr  [3];
  logic [7:0]  ram_wdata [3];
  logic [7:0]  ram_rdata [3];
  logic        ram_en [3];
  logic        ram_we [3];

  logic [7:0]  mem [3][256];
  logic        pre_we;
  int          pre_g;
  logic [7:0]  pre_a, pre_d;

  int checks = 0;
  int failures = 0;

  logic [7:0] addr_seq[$];
  int  lat, en_cnt, we_cnt;
  bit  err_seen, busy_bad, tail_ok;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(
      .RAM_LAT    (g),
      .BIG_ENDIAN ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk       (clk),
      .clr       (clr),
      .req       (req[g]),
      .rw        (rw[g]),
      .dt        (dt[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .rdata     (rdata[g]),
      .moc       (moc[g]),
      .busy      (busy[g]),
      .err       (err[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g])
    );
    assign ram_rdata[g] = mem[g][ram_addr[g]];
  end

  // RAM models plus a bench-side preload port
  always @(posedge clk) begin
    if (pre_we)
      mem[pre_g][pre_a] <= pre_d;
    for (int g = 0; g < 3; g++)
      if (ram_en[g] && ram_we[g])
        mem[g][ram_addr[g]] <= ram_wdata[g];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input int g, input logic [7:0] a,
                         input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_g  = g;
    pre_a  = a;
    pre_d  = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  function automatic logic [31:0] seq4();
    if (addr_seq.size() < 4)
      return 32'hxxxx_xxxx;
    return {addr_seq[0], addr_seq[1], addr_seq[2], addr_seq[3]};
  endfunction

  // one request; inputs are scrambled after acceptance
  task automatic xfer(input int g, input logic r, input logic [1:0] d,
                      input logic [7:0] a, input logic [31:0] w);
    @(negedge clk);
    req[g] = 1'b1; rw[g] = r; dt[g] = d;
    addr[g] = a; wdata[g] = w;
    @(posedge clk);
    #1;
    req[g] = 1'b0; rw[g] = ~r; dt[g] = 2'b11;
    addr[g] = a ^ 8'h5A; wdata[g] = ~w;
    lat = 0; en_cnt = 0; we_cnt = 0;
    err_seen = 0; busy_bad = 0;
    addr_seq.delete();
    @(negedge clk);
    while (!moc[g] && lat < 60) begin
      if (err[g]) err_seen = 1;
      if (!busy[g]) busy_bad = 1;
      if (ram_en[g]) begin
        en_cnt++;
        addr_seq.push_back(ram_addr[g]);
        if (ram_we[g]) we_cnt++;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!busy[g] || ram_en[g]) busy_bad = 1;
    @(negedge clk);
    tail_ok = !moc[g] && !busy[g];
  endtask

  // rejected request: expect a lone err pulse and no RAM activity
  task automatic err_case(input string tag, input int g,
                          input logic [1:0] d, input logic [7:0] a);
    logic [31:0] rd0;
    bit en_any;
    rd0 = rdata[g];
    en_any = 0;
    @(negedge clk);
    req[g] = 1'b1; rw[g] = 1'b1; dt[g] = d; addr[g] = a;
    @(posedge clk);
    #1 req[g] = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, {31'd0, err[g]}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy[g]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (ram_en[g] || moc[g]) en_any = 1;
      @(negedge clk);
      if (i == 0)
        check({tag, "_err_len"}, {31'd0, err[g]}, 32'd0);
    end
    check({tag, "_no_ram"}, {31'd0, en_any}, 32'd0);
    check({tag, "_rdata"}, rdata[g], rd0);
  endtask

  initial begin
    int n_moc;
    pre_we = 1'b0; pre_g = 0; pre_a = '0; pre_d = '0;
    for (int g = 0; g < 3; g++) begin
      req[g] = 1'b0; rw[g] = 1'b0; dt[g] = 2'b00;
      addr[g] = '0; wdata[g] = '0;
    end
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", {rdata[0][7:0], 3'd0, moc[0], busy[0], err[0],
                      ram_en[0], ram_we[0], ram_addr[0], ram_wdata[0]},
          32'h0);
    check("rst_rdata", rdata[0], 32'h0);
    clr = 1'b0;

    // word read, big-endian, L=0
    preload(0, 8'h20, 8'hDE);
    preload(0, 8'h21, 8'hAD);
    preload(0, 8'h22, 8'hBE);
    preload(0, 8'h23, 8'hEF);
    xfer(0, 1'b1, 2'b10, 8'h20, 32'h0);
    check("rd_w_lat", lat, 4);
    check("rd_w_seq", seq4(), 32'h20212223);
    check("rd_w_data", rdata[0], 32'hDEADBEEF);
    check("rd_w_busy", {31'd0, busy_bad}, 32'd0);
    check("rd_w_tail", {31'd0, tail_ok}, 32'd1);

    // reset in the middle of a word write
    preload(0, 8'h12, 8'h55);
    preload(0, 8'h13, 8'h55);
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b0; dt[0] = 2'b10;
    addr[0] = 8'h10; wdata[0] = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    check("clr_ctl", {28'd0, moc[0], busy[0], ram_en[0], ram_we[0]},
          32'd0);
    check("clr_rdata", rdata[0], 32'h0);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_mem", {mem[0][8'h10], mem[0][8'h11],
                      mem[0][8'h12], mem[0][8'h13]}, 32'hA1B25555);

    // halfword write, L=1, then byte read back
    xfer(1, 1'b0, 2'b01, 8'h40, 32'h1234ABCD);
    check("hw_lat", lat, 4);
    check("hw_we", we_cnt, 4);
    check("hw_seq", seq4(), 32'h40404141);
    check("hw_mem", {16'd0, mem[1][8'h40], mem[1][8'h41]}, 32'hABCD);
    xfer(1, 1'b1, 2'b00, 8'h41, 32'h0);
    check("hw_rb_lat", lat, 2);
    check("hw_rb_data", rdata[1], 32'h000000CD);

    // word write wrapping past 0xFF, then read it back
    xfer(0, 1'b0, 2'b10, 8'hFE, 32'h01020304);
    check("wrap_lat", lat, 4);
    check("wrap_err", {31'd0, err_seen}, 32'd0);
    check("wrap_seq", seq4(), 32'hFEFF0001);
    check("wrap_mem", {mem[0][8'hFE], mem[0][8'hFF],
                       mem[0][8'h00], mem[0][8'h01]}, 32'h01020304);
    xfer(0, 1'b1, 2'b10, 8'hFE, 32'h0);
    check("wrap_rd", rdata[0], 32'h01020304);

    // reserved size and alignment
    err_case("dt11", 0, 2'b11, 8'h20);
    err_case("dt11_b", 1, 2'b11, 8'h41);
`ifdef MEM_ALIGN_CHECK_EN
    err_case("misal", 0, 2'b10, 8'h42);
`else
    xfer(0, 1'b1, 2'b10, 8'h42, 32'h0);
    check("misal_lat", lat, 4);
    check("misal_err", {31'd0, err_seen}, 32'd0);
    check("misal_seq", seq4(), 32'h42434445);
`endif

    // little-endian, L=2
    preload(2, 8'h30, 8'h11);
    preload(2, 8'h31, 8'h22);
    preload(2, 8'h32, 8'h33);
    preload(2, 8'h33, 8'h44);
    xfer(2, 1'b1, 2'b10, 8'h30, 32'h0);
    check("le_w_lat", lat, 12);
    check("le_w_data", rdata[2], 32'h44332211);
    xfer(2, 1'b1, 2'b00, 8'h31, 32'h0);
    check("le_b_lat", lat, 3);
    check("le_b_data", rdata[2], 32'h00000022);
    xfer(2, 1'b0, 2'b01, 8'h50, 32'h7777BEEF);
    check("le_h_we", we_cnt, 6);
    check("le_h_mem", {16'd0, mem[2][8'h50], mem[2][8'h51]}, 32'hEFBE);
    check("le_h_keep", rdata[2], 32'h00000022);

    // req held through moc, toggled during the second transfer
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; dt[0] = 2'b10; addr[0] = 8'h20;
    n_moc = 0;
    en_cnt = 0;
    addr_seq.delete();
    for (int c = 0; c < 40 && n_moc < 2; c++) begin
      @(negedge clk);
      if (ram_en[0]) begin
        en_cnt++;
        if (n_moc == 1) begin
          addr_seq.push_back(ram_addr[0]);
          req[0] = ~req[0];
        end
      end
      if (moc[0]) begin
        n_moc++;
        if (n_moc == 2) req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    check("b2b_moc", n_moc, 2);
    check("b2b_en", en_cnt, 8);
    check("b2b_seq", seq4(), 32'h20212223);
    check("b2b_data", rdata[0], 32'hDEADBEEF);
    en_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ram_en[0]) en_cnt++;
    end
    check("b2b_quiet", en_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
